// File: rtl/spi_fb_driver_param.sv
// spi_fb_driver_param: pixel framebuffer with a mode-0 SPI refresh engine for a PMOD OLED
module spi_fb_driver_param #(
  parameter int H_PIX = 80,
  parameter int V_PIX = 60,
  parameter int PIX_W = 8,
  parameter int SCLK_DIV = 4,
  localparam int NPIX = H_PIX * V_PIX,
  localparam int AW = $clog2(NPIX)
) (
  input  logic             CLK_50MHz,
  input  logic             RESET_N,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [PIX_W-1:0] WD,
  output logic [PIX_W-1:0] RD,
  input  logic             START,
  input  logic             AUTO,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic [7:0]       PMOD
);
  localparam int SW = PIX_W > 8 ? PIX_W : 8;
  localparam int CW = AW + 1 > 3 ? AW + 1 : 3;
  localparam int DW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(SW);
  typedef enum logic [1:0] {IDLE, CMD, PIX, GAP} state_t;
  state_t r_state, w_nstate;
  logic [PIX_W-1:0] r_fb [NPIX];
  logic [PIX_W-1:0] r_rd, r_pf, w_pfd;
  logic [SW-1:0] r_sh, w_next;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit;
  logic [CW-1:0] r_cnt, w_pa, w_ci;
  logic [7:0] w_cmd;
  logic r_done, w_act, w_bend, w_wend, w_cmd_end, w_last, w_gend, w_start;
  logic w_cs_n, w_sclk, w_dc, w_mosi;
  always_ff @(posedge CLK_50MHz)
    if (WE && CW'(WA) < CW'(NPIX)) r_fb[WA] <= WD;
  always_ff @(posedge CLK_50MHz or negedge RESET_N)
    if (!RESET_N) r_rd <= '0;
    else r_rd <= CW'(WA) < CW'(NPIX) ? r_fb[WA] : '0;
  assign w_act = r_state == CMD || r_state == PIX;
  assign w_bend = w_act && r_div == DW'(SCLK_DIV - 1);
  assign w_wend = r_bit == BW'((r_state == CMD ? 8 : PIX_W) - 1);
  assign w_cmd_end = r_state == CMD && w_bend && w_wend && r_cnt == CW'(5);
  assign w_last = r_state == PIX && w_bend && w_wend && r_cnt == CW'(NPIX - 1);
  assign w_gend = r_state == GAP && r_div == DW'(SCLK_DIV - 1);
  assign w_start = (r_state == IDLE || r_state == GAP) && w_nstate == CMD;
  // the pixel after the one being shifted is fetched on its first cycle, hiding RAM latency
  assign w_pa = r_state == PIX ? r_cnt + 1'b1 : '0;
  assign w_pfd = w_pa < CW'(NPIX) ? r_fb[w_pa[AW-1:0]] : '0;
  assign w_ci = r_cnt + 1'b1;
  assign w_cmd = w_ci == CW'(1) || w_ci == CW'(4) ? 8'h00 :
                 w_ci == CW'(2) ? 8'(H_PIX - 1) :
                 w_ci == CW'(3) ? 8'h75 : 8'(V_PIX - 1);
  assign w_next = r_state == CMD && r_cnt != CW'(5) ? SW'(w_cmd) << (SW - 8) : SW'(r_pf) << (SW - PIX_W);
  always_ff @(posedge CLK_50MHz or negedge RESET_N)
    if (!RESET_N) begin
      r_div <= '0;
      r_bit <= '0;
      r_cnt <= '0;
      r_sh <= '0;
      r_pf <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_act && r_div == '0 && r_bit == '0) r_pf <= w_pfd;
      if (w_start) begin
        r_div <= '0;
        r_bit <= '0;
        r_cnt <= '0;
        r_sh <= SW'(8'h15) << (SW - 8);
      end else if (w_act) begin
        r_div <= w_bend ? '0 : r_div + 1'b1;
        if (w_bend) begin
          r_bit <= w_wend ? '0 : r_bit + 1'b1;
          r_sh <= w_wend ? w_next : r_sh << 1;
          if (w_wend) r_cnt <= w_cmd_end ? '0 : r_cnt + 1'b1;
        end
      end else r_div <= w_gend || r_state == IDLE ? '0 : r_div + 1'b1;
    end
  always_ff @(posedge CLK_50MHz or negedge RESET_N)
    if (!RESET_N) r_state <= IDLE;
    else r_state <= w_nstate;
  always_comb
    w_nstate = r_state == IDLE ? (START || AUTO ? CMD : IDLE) :
               r_state == CMD ? (w_cmd_end ? PIX : CMD) :
               r_state == PIX ? (w_last ? GAP : PIX) :
               (w_gend ? (AUTO ? CMD : IDLE) : GAP);
  always_comb begin
    w_cs_n = !w_act;
    w_sclk = w_act && r_div >= DW'(SCLK_DIV / 2);
    w_dc = r_state == PIX;
    w_mosi = w_act && r_sh[SW-1];
  end
  assign BUSY = r_state != IDLE;
  assign FRAME_DONE = r_done;
  assign RD = r_rd;
  assign PMOD = {3'b111, w_dc, w_sclk, 1'b0, w_mosi, w_cs_n};
endmodule

// File: tb/tb_spi_fb_driver_param.sv
// tb_spi_fb_driver_param: framebuffer vectors plus SPI-decoding scoreboard for the refresh engine
module tb_spi_fb_driver_param;
  logic clk = 0, rst_n = 0, we = 0, start_a = 0, start_b = 0, auto_a = 0, sel = 0;
  logic [2:0] wa = 0;
  logic [15:0] wd = 0;
  logic [7:0] rd_a, rd_c, pmod_a, pmod_b, pmod_c;
  logic [15:0] rd_b;
  logic busy_a, busy_b, busy_c, fd_a, fd_b, fd_c;
  int nchk = 0, nfail = 0;
  logic [16:0] qe [$];
  logic [7:0] mdl_a [8];
  logic [15:0] mdl_b [8];
  typedef struct { logic we; logic [2:0] wa; logic [7:0] wd; logic [7:0] ea; logic [7:0] ec; } vec_t;
  vec_t vt [10];
  logic [7:0] pm;
  logic [15:0] sh = 0, w;
  logic [16:0] e;
  logic p_sclk = 0, p_mosi = 0, p_dc = 0, p_cs = 1;
  int wl, nb = 0, cs_low = 0, cs_high = 0, flen = 0, gap = 0, frames = 0, dones = 0, cyc = 0, ldone = 0, pdone = 0;

  always #5 clk = ~clk;

  spi_fb_driver_param #(.H_PIX(4), .V_PIX(2), .PIX_W(8), .SCLK_DIV(4)) dut_a (
    .CLK_50MHz(clk), .RESET_N(rst_n), .WE(we), .WA(wa), .WD(wd[7:0]), .RD(rd_a),
    .START(start_a), .AUTO(auto_a), .BUSY(busy_a), .FRAME_DONE(fd_a), .PMOD(pmod_a));
  spi_fb_driver_param #(.H_PIX(4), .V_PIX(2), .PIX_W(16), .SCLK_DIV(2)) dut_b (
    .CLK_50MHz(clk), .RESET_N(rst_n), .WE(we), .WA(wa), .WD(wd), .RD(rd_b),
    .START(start_b), .AUTO(1'b0), .BUSY(busy_b), .FRAME_DONE(fd_b), .PMOD(pmod_b));
  spi_fb_driver_param #(.H_PIX(3), .V_PIX(2), .PIX_W(8), .SCLK_DIV(2)) dut_c (
    .CLK_50MHz(clk), .RESET_N(rst_n), .WE(we), .WA(wa), .WD(wd[7:0]), .RD(rd_c),
    .START(1'b0), .AUTO(1'b0), .BUSY(busy_c), .FRAME_DONE(fd_c), .PMOD(pmod_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_cmd();
    logic [7:0] cb [6] = '{8'h15, 8'h00, 8'h03, 8'h75, 8'h00, 8'h01};
    foreach (cb[i]) qe.push_back({1'b0, 8'h00, cb[i]});
  endtask

  task automatic push_frame(input bit b);
    push_cmd();
    for (int i = 0; i < 8; i++) qe.push_back({1'b1, b ? mdl_b[i] : {8'h00, mdl_a[i]}});
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1; we = 1; wa = a; wd = d;
    @(posedge clk); #1; we = 0;
    mdl_a[a] = d[7:0];
    mdl_b[a] = d;
  endtask

  task automatic pulse_start(input bit b);
    @(posedge clk); #1; if (b) start_b = 1; else start_a = 1;
    @(posedge clk); #1; start_a = 0; start_b = 0;
  endtask

  task automatic wait_frames(input int n, input int bound);
    int k = 0;
    while (frames < n && k < bound) begin
      @(posedge clk);
      k++;
    end
    chk("frame_timeout", 32'(frames >= n), 1);
  endtask

  // SPI monitor: decodes words on rising SCLK and scores them against the expected queue
  always @(negedge clk) begin
    pm = sel ? pmod_b : pmod_a;
    cyc++;
    chk("pmod_const", {28'd0, pm[7:5], pm[2]}, 32'b1110);
    if (pm[3] && p_sclk) chk("mode0_stable", {30'd0, pm[1], pm[4]}, {30'd0, p_mosi, p_dc});
    if (!pm[0] && pm[3] && !p_sclk) begin
      sh = {sh[14:0], pm[1]};
      nb++;
      wl = pm[4] && sel ? 16 : 8;
      if (nb == wl) begin
        w = wl == 8 ? {8'h00, sh[7:0]} : sh;
        if (qe.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL spi_extra_word: got %h expected none", {pm[4], w});
        end else begin
          e = qe.pop_front();
          chk("spi_word", {15'd0, pm[4], w}, {15'd0, e});
        end
        nb = 0;
      end
    end
    if (pm[0]) nb = 0;
    if (!pm[0]) cs_low++; else cs_high++;
    if (pm[0] && !p_cs) begin flen = cs_low; cs_low = 0; frames++; end
    if (!pm[0] && p_cs) begin gap = cs_high; cs_high = 0; end
    if (sel ? fd_b : fd_a) begin dones++; pdone = ldone; ldone = cyc; end
    p_sclk = pm[3];
    p_mosi = pm[1];
    p_dc = pm[4];
    p_cs = pm[0];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 3'd0, 8'hE5, 8'h10, 8'h10};
    vt[1] = '{1'b0, 3'd0, 8'h00, 8'hE5, 8'hE5};
    vt[2] = '{1'b1, 3'd2, 8'hFF, 8'h12, 8'h12};
    vt[3] = '{1'b0, 3'd2, 8'h00, 8'hFF, 8'hFF};
    vt[4] = '{1'b1, 3'd6, 8'h77, 8'h16, 8'h00};
    vt[5] = '{1'b0, 3'd6, 8'h00, 8'h77, 8'h00};
    vt[6] = '{1'b0, 3'd7, 8'h00, 8'h17, 8'h00};
    vt[7] = '{1'b1, 3'd5, 8'h3C, 8'h15, 8'h15};
    vt[8] = '{1'b0, 3'd5, 8'h00, 8'h3C, 8'h3C};
    vt[9] = '{1'b0, 3'd1, 8'h00, 8'h11, 8'h11};
    repeat (3) @(posedge clk); #1;
    chk("rst_pmod_a", {24'd0, pmod_a}, 32'hE1);
    chk("rst_pmod_b", {24'd0, pmod_b}, 32'hE1);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_frame_done", {31'd0, fd_a}, 0);
    chk("rst_rd", {24'd0, rd_a}, 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) wr(3'(i), {8'hB0 + 8'(i), 8'h10 + 8'(i)});
    foreach (vt[i]) begin
      @(posedge clk); #1; we = vt[i].we; wa = vt[i].wa; wd = {8'hC0, vt[i].wd};
      @(posedge clk); #1;
      chk("rd_a", {24'd0, rd_a}, {24'd0, vt[i].ea});
      chk("rd_c", {24'd0, rd_c}, {24'd0, vt[i].ec});
      if (vt[i].we) begin mdl_a[vt[i].wa] = vt[i].wd; mdl_b[vt[i].wa] = {8'hC0, vt[i].wd}; end
    end
    we = 0;
    push_frame(0);
    pulse_start(0);
    chk("busy_after_start", {31'd0, busy_a}, 1);
    chk("cs_low_first", {31'd0, pmod_a[0]}, 0);
    repeat (300) @(posedge clk);
    pulse_start(0);
    wait_frames(1, 1000);
    chk("frame_len_a", flen, 448);
    chk("done_count_1", dones, 1);
    repeat (600) @(posedge clk); #1;
    chk("start_not_queued", frames, 1);
    chk("idle_after_frame", {31'd0, busy_a}, 0);
    chk("queue_empty_1", qe.size(), 0);
    push_cmd();
    for (int i = 0; i < 8; i++) qe.push_back({1'b1, 8'h00, i == 7 ? 8'h5A : mdl_a[i]});
    pulse_start(0);
    repeat (230) @(posedge clk); #1; we = 1; wa = 7; wd = 16'hC05A;
    @(posedge clk); #1; wa = 2; wd = 16'hC0A5;
    @(posedge clk); #1; we = 0;
    mdl_a[7] = 8'h5A; mdl_b[7] = 16'hC05A; mdl_a[2] = 8'hA5; mdl_b[2] = 16'hC0A5;
    wait_frames(2, 1000);
    chk("frame_len_wr", flen, 448);
    chk("queue_empty_2", qe.size(), 0);
    @(posedge clk); #1; wa = 2;
    @(posedge clk); #1;
    chk("rd_after_pix_write", {24'd0, rd_a}, 32'hA5);
    push_frame(0); push_frame(0); push_frame(0);
    @(posedge clk); #1; auto_a = 1;
    wait_frames(3, 1000);
    wait_frames(4, 1000);
    chk("auto_gap", gap, 4);
    chk("auto_period", ldone - pdone, 452);
    chk("auto_frame_len", flen, 448);
    repeat (100) @(posedge clk); #1; auto_a = 0;
    wait_frames(5, 1000);
    chk("auto_gap_2", gap, 4);
    repeat (700) @(posedge clk); #1;
    chk("auto_clear_stops", frames, 5);
    chk("auto_clear_idle", {31'd0, busy_a}, 0);
    chk("done_count_5", dones, 5);
    chk("queue_empty_3", qe.size(), 0);
    push_frame(0);
    pulse_start(0);
    repeat (399) @(posedge clk); #1;
    chk("cs_low_pre_rst", {31'd0, pmod_a[0]}, 0);
    rst_n = 0; #1;
    chk("rst_mid_cs", {31'd0, pmod_a[0]}, 1);
    chk("rst_mid_sclk", {31'd0, pmod_a[3]}, 0);
    chk("rst_mid_busy", {31'd0, busy_a}, 0);
    chk("rst_mid_rd", {24'd0, rd_a}, 0);
    @(posedge clk); #1; rst_n = 1;
    qe.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; wa = 3'(i);
      @(posedge clk); #1;
      chk("fb_kept_a", {24'd0, rd_a}, {24'd0, mdl_a[i]});
      chk("fb_kept_c", {24'd0, rd_c}, i < 6 ? {24'd0, mdl_a[i]} : 32'd0);
    end
    sel = 1;
    repeat (2) @(posedge clk);
    push_frame(1);
    pulse_start(1);
    chk("busy_b", {31'd0, busy_b}, 1);
    wait_frames(7, 1000);
    chk("frame_len_b", flen, 352);
    chk("done_count_b", dones, 6);
    chk("queue_empty_b", qe.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
